// File: rtl/arith_div.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned.
// Divide-by-zero and signed overflow finish right after the accepting edge.
// Optional macro ARITH_DIV_EARLY_EN: finish right after the accepting edge
// when |B| > |A|, with quot=0 and rem=A.
module arith_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             ofl,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             ofl_q, ofl_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_dz, is_ofl, is_early, is_special;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;

  // Operand classification at the accepting edge
  always_comb begin
    a_neg      = sign & A[WIDTH-1];
    b_neg      = sign & B[WIDTH-1];
    a_mag      = a_neg ? ('0 - A) : A;
    b_mag      = b_neg ? ('0 - B) : B;
    is_dz      = (B == '0);
    is_ofl     = sign & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
`ifdef ARITH_DIV_EARLY_EN
    is_early   = ~is_dz & (b_mag > a_mag);
`else
    is_early   = 1'b0;
`endif
    is_special = is_dz | is_ofl | is_early;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract divisor
  always_comb begin
    shifted = {prem_q, dvd_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dsr_q};
    // Non-negative difference is always below the divisor, so both top bits are 0
    q_bit   = (diff[WIDTH+1:WIDTH] == 2'b00);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = is_special ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  // Datapath next-value logic
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    prem_d = prem_q;
    dsr_d  = dsr_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    negq_d = negq_q;
    negr_d = negr_q;
    ofl_d  = ofl_q;
    dz_d   = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ofl_d  = 1'b0;
          dz_d   = 1'b0;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          dvd_d  = a_mag;
          dsr_d  = b_mag;
          prem_d = '0;
          cnt_d  = '0;
          if (is_dz) begin
            quot_d = '1;
            rem_d  = A;
            dz_d   = 1'b1;
          end else if (is_ofl) begin
            quot_d = {1'b1, {(WIDTH-1){1'b0}}};
            rem_d  = '0;
            ofl_d  = 1'b1;
          end else if (is_early) begin
            quot_d = '0;
            rem_d  = A;
          end
        end
      end
      S_RUN: begin
        prem_d = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d  = {dvd_q[WIDTH-2:0], q_bit};
        cnt_d  = cnt_q + CW'(1);
      end
      S_FIX: begin
        quot_d = negq_q ? ('0 - dvd_q) : dvd_q;
        rem_d  = negr_q ? ('0 - prem_q) : prem_q;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      prem_q <= '0;
      dsr_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      ofl_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      prem_q <= prem_d;
      dsr_q  <= dsr_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      ofl_q  <= ofl_d;
      dz_q   <= dz_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign ofl      = ofl_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_arith_div.sv
// Directed bench for arith_div: vector table plus hand-written sequences
// for busy-ignore, reset abort and back-to-back start.
// Latency is counted in edges with the accepting edge as edge 1.
module tb_arith_div;

  localparam int W = 16;

`ifdef ARITH_DIV_EARLY_EN
  localparam int EL = 1;
`else
  localparam int EL = 18;
`endif

  logic         clk = 1'b0;
  logic         rst, start, sign;
  logic [W-1:0] A, B;
  logic         busy, done, ofl, div_zero;
  logic [W-1:0] quot, rem;

  arith_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sign(sign),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .ofl(ofl), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ofl;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tbl [11];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    bit seen, busy_ok;
    @(negedge clk);
    A = v.a; B = v.b; sign = v.sgn; start = 1'b1;
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        sign = ~sign;
      end
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    chk($sformatf("v%0d latency", idx), n, v.lat);
    chk($sformatf("v%0d busy", idx), {31'd0, busy_ok}, 32'd1);
    chk($sformatf("v%0d busy_at_done", idx), busy, 0);
    chk($sformatf("v%0d quot", idx), quot, v.q);
    chk($sformatf("v%0d rem", idx), rem, v.r);
    chk($sformatf("v%0d ofl", idx), ofl, v.ofl);
    chk($sformatf("v%0d div_zero", idx), div_zero, v.dz);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_pulse", idx), done, 0);
    chk($sformatf("v%0d quot_hold", idx), quot, v.q);
  endtask

  initial begin
    int n;
    bit seen, bad;

    tbl[0]  = '{16'd1000, 16'd7,    1'b0, 16'd142,  16'd6,    1'b0, 1'b0, 18};
    tbl[1]  = '{16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18};
    tbl[2]  = '{16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0, 1'b0, 18};
    tbl[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1};
    tbl[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0, 1};
    tbl[5]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, EL};
    tbl[6]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
    tbl[7]  = '{16'd3,    16'd10,   1'b0, 16'd0,    16'd3,    1'b0, 1'b0, EL};
    tbl[8]  = '{16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18};
    tbl[9]  = '{16'hFFFD, 16'd10,   1'b1, 16'h0000, 16'hFFFD, 1'b0, 1'b0, EL};
    tbl[10] = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quot", quot, 0);
    chk("reset rem", rem, 0);
    chk("reset ofl", ofl, 0);
    chk("reset div_zero", div_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(tbl[i], i);

    // start pulse with new operands mid-operation must be ignored
    @(negedge clk);
    A = 16'd100; B = 16'd3; sign = 1'b0; start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
      if (n == 5) begin
        chk("ignore busy", busy, 1);
        start = 1'b1; A = 16'd9; B = 16'd9;
      end
      if (n == 6) start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    chk("ignore latency", n, 18);
    chk("ignore quot", quot, 33);
    chk("ignore rem", rem, 1);
    @(posedge clk); #1;

    // reset at iteration 8 aborts without a done pulse
    @(negedge clk);
    A = 16'd100; B = 16'd3; sign = 1'b0; start = 1'b1;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (done !== 1'b0) bad = 1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quot", quot, 0);
    chk("abort rem", rem, 0);
    chk("abort ofl", ofl, 0);
    chk("abort div_zero", div_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    chk("abort no_done", {31'd0, bad}, 0);

    // start held from the done cycle: ignored there, accepted in the next IDLE cycle
    @(negedge clk);
    A = 16'd50; B = 16'd5; sign = 1'b0; start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    chk("b2b first latency", n, 18);
    chk("b2b first quot", quot, 10);
    A = 16'd60; B = 16'd4; start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 2) start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    chk("b2b second latency", n, 19);
    chk("b2b second quot", quot, 15);
    chk("b2b second rem", rem, 0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
